// File: rtl/memoria_instrucoes_programavel_pkg.sv
// Shared definitions for the programmable instruction memory.
//   estado_t         : init/load sequencer states
//   INSTR_NOP_PADRAO : default NOP encoding (all zeros)
package pkg_memoria_instrucoes;

  typedef enum logic [1:0] {
    LIMPANDO   = 2'd0,
    OCIOSO     = 2'd1,
    CARREGANDO = 2'd2
  } estado_t;

  localparam int INSTR_NOP_PADRAO = 0;

endpackage

// File: rtl/memoria_instrucoes_programavel_ram.sv
// Simple dual-port synchronous RAM (1 write port, 1 registered read port).
// Ports:
//   clock        : rising-edge clock
//   i_escrita_en : write enable
//   i_end_esc    : write word address
//   i_dado_esc   : write data
//   i_leitura_en : read enable (read register holds when low)
//   i_end_leit   : read word address
//   o_dado_leit  : registered read data
// The array and read register carry no reset; contents are defined by the
// clearing sequence in the parent.
module ram_sincrona_1e1l #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 1024,
  parameter int LARGURA_END  = $clog2(PROFUNDIDADE)
) (
  input  logic                   clock,
  input  logic                   i_escrita_en,
  input  logic [LARGURA_END-1:0] i_end_esc,
  input  logic [LARGURA-1:0]     i_dado_esc,
  input  logic                   i_leitura_en,
  input  logic [LARGURA_END-1:0] i_end_leit,
  output logic [LARGURA-1:0]     o_dado_leit
);

  logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
  logic [LARGURA-1:0] r_dado_leit;

  always_ff @(posedge clock) begin
    if (i_escrita_en) r_mem[i_end_esc] <= i_dado_esc;
    if (i_leitura_en) r_dado_leit <= r_mem[i_end_leit];
  end

  assign o_dado_leit = r_dado_leit;

endmodule

// File: rtl/memoria_instrucoes_programavel.sv
// Programmable instruction memory for the fetch stage.
// Synchronous word fetch (latency 1) with valid flag and out-of-range fault,
// a valid/ready load port for writing a program image, and an init sequencer
// that clears every word to INSTR_NOP after reset.
// Ports:
//   clock, reset (async, active-low)
//   endereco, leitura_en              : fetch request
//   instrucao, instrucao_valida,
//   erro_endereco                     : registered fetch result
//   prog_inicio, prog_dado,
//   prog_valido, prog_fim             : load stream in
//   prog_pronto, prog_cheio, ocupado  : load/sequencer status
module memoria_instrucoes_programavel
  import pkg_memoria_instrucoes::*;
#(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 32,
  parameter int PROFUNDIDADE = 1024,
  parameter logic [LARGURA_DADO-1:0] INSTR_NOP = LARGURA_DADO'(INSTR_NOP_PADRAO)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LARGURA_END-1:0]  endereco,
  input  logic                    leitura_en,
  output logic [LARGURA_DADO-1:0] instrucao,
  output logic                    instrucao_valida,
  output logic                    erro_endereco,
  input  logic                    prog_inicio,
  input  logic [LARGURA_DADO-1:0] prog_dado,
  input  logic                    prog_valido,
  output logic                    prog_pronto,
  input  logic                    prog_fim,
  output logic                    prog_cheio,
  output logic                    ocupado
);

  localparam int LARGURA_CONT = $clog2(PROFUNDIDADE);
  localparam logic [LARGURA_CONT-1:0] ULTIMO = LARGURA_CONT'(PROFUNDIDADE - 1);
  localparam logic [LARGURA_END-1:0]  LIMITE = LARGURA_END'(PROFUNDIDADE);

  estado_t                  r_estado;
  logic [LARGURA_CONT-1:0]  r_contador;
  logic                     r_prog_pronto;
  logic                     r_prog_cheio;
  logic                     r_ocupado;
  logic                     r_fonte_ram;   // 1: instrucao comes from the RAM read register
  logic                     r_valida;
  logic                     r_erro;

  logic                     w_em_faixa;
  logic                     w_escrita;
  logic                     w_aceita_palavra;
  logic                     w_leitura_ram;
  logic [LARGURA_DADO-1:0]  w_dado_esc;
  logic [LARGURA_DADO-1:0]  w_dado_ram;

  // Full-width compare so high address bits never alias into the array.
  assign w_em_faixa       = (endereco < LIMITE);
  assign w_aceita_palavra = (r_estado == CARREGANDO) && prog_valido && r_prog_pronto;
  assign w_escrita        = (r_estado == LIMPANDO) || w_aceita_palavra;
  assign w_dado_esc       = (r_estado == LIMPANDO) ? INSTR_NOP : prog_dado;
  assign w_leitura_ram    = leitura_en && (r_estado == OCIOSO) && w_em_faixa;

  ram_sincrona_1e1l #(
    .LARGURA      (LARGURA_DADO),
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA_END  (LARGURA_CONT)
  ) u_ram (
    .clock        (clock),
    .i_escrita_en (w_escrita),
    .i_end_esc    (r_contador),
    .i_dado_esc   (w_dado_esc),
    .i_leitura_en (w_leitura_ram),
    .i_end_leit   (endereco[LARGURA_CONT-1:0]),
    .o_dado_leit  (w_dado_ram)
  );

  // Sequencer: clear after reset, then idle/serve fetches, or accept a load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado      <= LIMPANDO;
      r_contador    <= '0;
      r_prog_pronto <= 1'b0;
      r_prog_cheio  <= 1'b0;
      r_ocupado     <= 1'b1;
    end else begin
      case (r_estado)
        LIMPANDO: begin
          if (r_contador == ULTIMO) begin
            r_estado   <= OCIOSO;
            r_contador <= '0;
            r_ocupado  <= 1'b0;
          end else begin
            r_contador <= r_contador + 1'b1;
          end
        end
        OCIOSO: begin
          if (prog_inicio) begin
            r_estado      <= CARREGANDO;
            r_contador    <= '0;
            r_prog_cheio  <= 1'b0;
            r_prog_pronto <= 1'b1;
            r_ocupado     <= 1'b1;
          end
        end
        CARREGANDO: begin
          // A word written to the last location ends the load; no wrap-around.
          if (w_aceita_palavra && (r_contador == ULTIMO)) begin
            r_estado      <= OCIOSO;
            r_prog_cheio  <= 1'b1;
            r_prog_pronto <= 1'b0;
            r_ocupado     <= 1'b0;
          end else begin
            if (w_aceita_palavra) r_contador <= r_contador + 1'b1;
            if (prog_fim) begin
              r_estado      <= OCIOSO;
              r_prog_pronto <= 1'b0;
              r_ocupado     <= 1'b0;
            end
          end
        end
        default: begin
          r_estado      <= LIMPANDO;
          r_contador    <= '0;
          r_prog_pronto <= 1'b0;
          r_ocupado     <= 1'b1;
        end
      endcase
    end
  end

  // Fetch result flags; with leitura_en low the result holds, only valid drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fonte_ram <= 1'b0;
      r_valida    <= 1'b0;
      r_erro      <= 1'b0;
    end else if (leitura_en) begin
      if (r_estado == OCIOSO) begin
        r_fonte_ram <= w_em_faixa;
        r_valida    <= w_em_faixa;
        r_erro      <= !w_em_faixa;
      end else begin
        r_fonte_ram <= 1'b0;
        r_valida    <= 1'b0;
        r_erro      <= 1'b0;
      end
    end else begin
      r_valida <= 1'b0;
    end
  end

  assign instrucao        = r_fonte_ram ? w_dado_ram : INSTR_NOP;
  assign instrucao_valida = r_valida;
  assign erro_endereco    = r_erro;
  assign prog_pronto      = r_prog_pronto;
  assign prog_cheio       = r_prog_cheio;
  assign ocupado          = r_ocupado;

endmodule

// File: tb/tb_memoria_instrucoes_programavel.sv
// Directed bench for memoria_instrucoes_programavel at depth 16.
module tb_memoria_instrucoes_programavel;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] endereco;
  logic        leitura_en;
  logic [31:0] instrucao;
  logic        instrucao_valida;
  logic        erro_endereco;
  logic        prog_inicio;
  logic [31:0] prog_dado;
  logic        prog_valido;
  logic        prog_pronto;
  logic        prog_fim;
  logic        prog_cheio;
  logic        ocupado;

  int n_assert = 0;
  int n_fail   = 0;

  memoria_instrucoes_programavel #(
    .LARGURA_DADO (32),
    .LARGURA_END  (32),
    .PROFUNDIDADE (16),
    .INSTR_NOP    (32'h0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .endereco         (endereco),
    .leitura_en       (leitura_en),
    .instrucao        (instrucao),
    .instrucao_valida (instrucao_valida),
    .erro_endereco    (erro_endereco),
    .prog_inicio      (prog_inicio),
    .prog_dado        (prog_dado),
    .prog_valido      (prog_valido),
    .prog_pronto      (prog_pronto),
    .prog_fim         (prog_fim),
    .prog_cheio       (prog_cheio),
    .ocupado          (ocupado)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] e_instr,
                       input logic e_val, input logic e_err, input string tag);
    endereco   = addr;
    leitura_en = 1'b1;
    tick();
    leitura_en = 1'b0;
    chk({tag, ".instr"}, instrucao, e_instr);
    chk({tag, ".valida"}, {31'b0, instrucao_valida}, {31'b0, e_val});
    chk({tag, ".erro"}, {31'b0, erro_endereco}, {31'b0, e_err});
  endtask

  // Count cycles until ocupado falls, bounded.
  task automatic espera_limpeza(input string tag);
    int n;
    n = 0;
    while (ocupado && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".ciclos_ocupado"}, n, 32'd16);
  endtask

  task automatic inicia_carga(input string tag);
    prog_inicio = 1'b1;
    tick();
    prog_inicio = 1'b0;
    chk({tag, ".pronto"}, {31'b0, prog_pronto}, 32'd1);
    chk({tag, ".ocupado"}, {31'b0, ocupado}, 32'd1);
    chk({tag, ".cheio_limpo"}, {31'b0, prog_cheio}, 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    endereco    = '0;
    leitura_en  = 1'b0;
    prog_inicio = 1'b0;
    prog_dado   = '0;
    prog_valido = 1'b0;
    prog_fim    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst.ocupado", {31'b0, ocupado}, 32'd1);
    chk("rst.valida", {31'b0, instrucao_valida}, 32'd0);
    chk("rst.erro", {31'b0, erro_endereco}, 32'd0);
    chk("rst.instr", instrucao, 32'h0);
    chk("rst.pronto", {31'b0, prog_pronto}, 32'd0);
    chk("rst.cheio", {31'b0, prog_cheio}, 32'd0);

    // Release; one fetch while clearing (busy: no error even out of range)
    reset = 1'b1;
    prog_inicio = 1'b1;   // ignored while clearing
    endereco = 32'd20;
    leitura_en = 1'b1;
    tick();
    leitura_en = 1'b0;
    prog_inicio = 1'b0;
    chk("busy.valida", {31'b0, instrucao_valida}, 32'd0);
    chk("busy.erro", {31'b0, erro_endereco}, 32'd0);
    chk("busy.pronto", {31'b0, prog_pronto}, 32'd0);
    begin
      int n;
      n = 1;
      while (ocupado && n < 40) begin
        tick();
        n++;
      end
      chk("init.ciclos_ocupado", n, 32'd16);
    end

    // Cleared array reads all NOP
    for (int a = 0; a < 16; a++) fetch(a, 32'h0, 1'b1, 1'b0, "limpo");

    // Load 3 words, prog_fim with the last
    inicia_carga("carga3");
    prog_valido = 1'b1;
    prog_dado = 32'hA; tick();
    prog_dado = 32'hB; tick();
    prog_dado = 32'hC; prog_fim = 1'b1; tick();
    prog_valido = 1'b0; prog_fim = 1'b0;
    chk("carga3.pronto_fim", {31'b0, prog_pronto}, 32'd0);
    chk("carga3.ocupado_fim", {31'b0, ocupado}, 32'd0);
    chk("carga3.cheio", {31'b0, prog_cheio}, 32'd0);
    fetch(0, 32'hA, 1'b1, 1'b0, "carga3.w0");
    fetch(1, 32'hB, 1'b1, 1'b0, "carga3.w1");
    fetch(2, 32'hC, 1'b1, 1'b0, "carga3.w2");
    tick();
    chk("hold.instr", instrucao, 32'hC);
    chk("hold.valida", {31'b0, instrucao_valida}, 32'd0);
    fetch(3, 32'h0, 1'b1, 1'b0, "carga3.w3");

    // Out-of-range fetches
    fetch(32'd16, 32'h0, 1'b0, 1'b1, "falha16");
    fetch(32'h8000_0010, 32'h0, 1'b0, 1'b1, "falha_alto");
    tick();
    chk("falha.hold_erro", {31'b0, erro_endereco}, 32'd1);
    fetch(32'h8000_0000, 32'h0, 1'b0, 1'b1, "falha_alias0");

    // Overfill: 20 words into depth 16
    inicia_carga("cheia");
    for (int i = 0; i < 20; i++) begin
      prog_dado = 32'h100 + i;
      prog_valido = 1'b1;
      tick();
      if (i == 14) chk("cheia.pronto14", {31'b0, prog_pronto}, 32'd1);
      if (i == 15) begin
        chk("cheia.pronto15", {31'b0, prog_pronto}, 32'd0);
        chk("cheia.cheio", {31'b0, prog_cheio}, 32'd1);
        chk("cheia.ocupado", {31'b0, ocupado}, 32'd0);
      end
    end
    prog_valido = 1'b0;
    fetch(15, 32'h10F, 1'b1, 1'b0, "cheia.w15");
    fetch(0, 32'h100, 1'b1, 1'b0, "cheia.w0");
    fetch(7, 32'h107, 1'b1, 1'b0, "cheia.w7");

    // Gapped handshake: only cycles with prog_valido store, sequentially
    inicia_carga("gaps");
    for (int k = 0; k < 6; k++) begin
      prog_dado = 32'hD0 + k;
      prog_valido = (k == 0 || k == 3 || k == 5);
      prog_fim = (k == 5);
      tick();
    end
    prog_valido = 1'b0; prog_fim = 1'b0;
    chk("gaps.cheio", {31'b0, prog_cheio}, 32'd0);
    fetch(0, 32'hD0, 1'b1, 1'b0, "gaps.w0");
    fetch(1, 32'hD3, 1'b1, 1'b0, "gaps.w1");
    fetch(2, 32'hD5, 1'b1, 1'b0, "gaps.w2");
    fetch(3, 32'h103, 1'b1, 1'b0, "gaps.w3_antigo");

    // Reset in the middle of a load
    inicia_carga("abort");
    prog_valido = 1'b1;
    prog_dado = 32'hE0; tick();
    prog_dado = 32'hE1; tick();
    prog_valido = 1'b0;
    reset = 1'b0;
    #2;
    chk("abort.ocupado", {31'b0, ocupado}, 32'd1);
    chk("abort.pronto", {31'b0, prog_pronto}, 32'd0);
    tick();
    reset = 1'b1;
    espera_limpeza("abort");
    fetch(0, 32'h0, 1'b1, 1'b0, "abort.w0");
    fetch(1, 32'h0, 1'b1, 1'b0, "abort.w1");
    fetch(5, 32'h0, 1'b1, 1'b0, "abort.w5");
    fetch(15, 32'h0, 1'b1, 1'b0, "abort.w15");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected end before 200000");
    $fatal(1, "timeout");
  end

endmodule
